// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// clear-sequencer states and port slice helper.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_AW    = 5;
    localparam int unsigned DEF_NREAD = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Low bit of port 'port' inside a flattened bus of 'w'-bit lanes.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned w);
        return port * w;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Software clear sequencer: walks every entry once, one per cycle, after a
// clr request seen in IDLE.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int unsigned AW = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    // One spare bit so the last index is detected without wrapping.
    localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

    clr_state_e    state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_en   = busy;
    assign clr_addr = cnt_q[AW-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read / single-write register file with registered,
// write-first reads, optional hardwired zero entry and sequenced clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned NREAD    = DEF_NREAD,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [NREAD*AW-1:0]    raddr,
    output logic [NREAD*WIDTH-1:0] rdata,
    input  logic                   clr,
    output logic                   busy
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam bit          ZR    = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             clr_en;
    logic [AW-1:0]    clr_addr;
    logic             wr_ok;

    regfile_clr_seq #(
        .AW(AW)
    ) u_clr_seq (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // A clr request in IDLE takes priority over a same-edge write.
    assign wr_ok = we && !busy && !clr && !(ZR && (waddr == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem[AW'(j)] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        localparam int unsigned RLO = slice_lo(gi, AW);
        localparam int unsigned WLO = slice_lo(gi, WIDTH);

        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd_d, rd_q;

        assign ra = raddr[RLO +: AW];

        always_comb begin
            rd_d = mem[ra];
            if (busy) begin
                rd_d = '0;
            end else if (ZR && (ra == '0)) begin
                rd_d = '0;
            end else if (wr_ok && (waddr == ra)) begin
                rd_d = wdata;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rdata[WLO +: WIDTH] = rd_q;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file. Successor to the single-cycle CPU's 2-read/1-write 32x32 register bank.
- Adds configurable width, depth and read-port count, registered reads with write-to-read forwarding, optional hardwired zero register, and a sequenced software clear.
- Sits in the decode stage. Read addresses come from the instruction fields. Write port is driven by writeback.

Parameters:
- WIDTH, 32, data word width in bits.
- AW, 5, address width; DEPTH = 2**AW entries.
- NREAD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- raddr  input  NREAD*AW  read addresses; port i at bits [i*AW +: AW].
- rdata  output  NREAD*WIDTH  registered read data; port i at bits [i*WIDTH +: WIDTH].
- clr  input  1  single-cycle request to zero all entries.
- busy  output  1  clear sequence in progress.

Behaviour:
- Reset (reset==0, asynchronous):
  - all DEPTH entries = 0, rdata = 0, busy = 0, state = IDLE, clear counter = 0.
  - Reset mid-clear aborts the clear; the block is in IDLE once reset releases.
- Write (IDLE only):
  - On posedge, if we==1 and not (ZERO_REG && waddr==0), mem[waddr] <= wdata.
  - Writes to entry 0 with ZERO_REG=1 are silently dropped.
- Read:
  - 1-cycle latency. On posedge, rdata[i] <= value for raddr[i] sampled at that edge.
  - Value is 0 if ZERO_REG && raddr[i]==0.
  - Otherwise, forwarding applies: if the edge also performs an accepted write with waddr==raddr[i], the value is wdata (write-first).
  - Otherwise the value is mem[raddr[i]].
  - Ports are independent; any number may address the same entry.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr==1 at a posedge. Counter loads 0.
  - CLEAR: each posedge zeroes mem[counter] and increments the counter. Wrap-around is not permitted.
  - After the edge that clears entry DEPTH-1, the FSM returns to IDLE.
  - busy==1 exactly while in CLEAR (DEPTH cycles, starting the cycle after clr is sampled).
  - clr and we at the same IDLE edge: clr wins, the write is dropped, and no forwarding occurs.
  - clr while in CLEAR is ignored; the sequence is not restarted.
  - we while busy is dropped; the writer must hold off until busy==0.
  - Reads while busy: rdata registers 0 on every port.
  - First edge with busy==0 accepts writes and returns real reads.
- Width rules: no arithmetic on data. The counter is AW+1 bits so DEPTH-1 is detected without overflow.
- No X propagation: out-of-range addresses are impossible by width.

Decomposition:
- Shared package regfile_pkg:
  - default WIDTH/AW/NREAD constants;
  - clear-state enum (IDLE, CLEAR);
  - helper function computing the port slice offsets.
- One natural sub-module: regfile_clr_seq. It holds the FSM and counter and outputs busy, clr_en and clr_addr.
- Storage, write and read/forwarding logic stay in regfile_mp.

Test Plan:
- Reset then read: release reset, raddr ports = {3,7} -> rdata = {0,0} one cycle later; busy = 0.
- Write then read: write 0xDEADBEEF to entry 5, next cycle raddr0=5 -> rdata0 = 0xDEADBEEF after 1 cycle. Entry 0 write of 0x12345678 -> read 0 returns 0.
- Forwarding: same edge we=1, waddr=9, wdata=0xA5A5A5A5, raddr0=raddr1=9 -> both rdata = 0xA5A5A5A5 after that edge.
- Clear sequence: fill all 32 entries with index+1, pulse clr -> busy high exactly 32 cycles; rdata = 0 while busy. Afterwards every entry reads 0.
- Collisions: clr and we (waddr=4, 0x55) on the same edge -> entry 4 not written. During CLEAR, a we to entry 31 is dropped and a second clr does not extend busy beyond 32 cycles.
- Async reset mid-clear: drop reset at clear count 10 -> busy=0 and rdata=0 immediately. After release, writes are accepted on the first edge. Repeat with NREAD=4, WIDTH=16, AW=3.
